dbi_capture_queue: RTL and testbench
====================================

Name: dbi_capture_queue

Overview:
- Parametrised successor to the CPU's single-register data-bus input latch, which captures dbi on clkdbi when cedbi is high.
- Captures bus read data into a show-ahead queue of DEPTH entries, clocked in the clkdbi domain.
- Optional byte-lane extraction and sign/zero extension are applied at capture time.
- Feeds instruction prefetch and operand reads to the datapath, which pops words as the microsequencer consumes them.
- DEPTH=1 with OVERWRITE=1 behaves as the single capture latch.

Parameters:
- DW, 16, data word width in bits; even, >=8.
- DEPTH, 4, number of queue entries; power of two, >=1.
- CW, 3, count width; must satisfy 2**CW > DEPTH.
- OVERWRITE, 0, behaviour of a push into a full queue: 0 = drop the word and flag overflow; 1 = replace the newest entry.

Ports:
- clkdbi  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- cedbi  in  1  clock enable; when low, no state changes.
- dbi  in  DW  bus read data.
- push  in  1  capture dbi this cycle.
- byte_op  in  1  byte access; extract one byte lane.
- odd  in  1  address bit 0; selects the high byte when byte_op=1.
- sext  in  1  byte sign-extend (1) or zero-extend (0); ignored for word access.
- pop  in  1  consume the head entry.
- flush  in  1  discard all entries and clear overflow.
- dout  out  DW  head entry; 0 when empty.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  CW  number of valid entries.
- overflow  out  1  sticky: a push was dropped.

Behaviour:
- Reset is asynchronous, active-low, on reset_n:
  - rptr=wptr=0, count=0, overflow=0.
  - dout=0, empty=1, full=0.
  - Storage contents are don't-care.
- With cedbi=0, all inputs are ignored and state holds.
- Capture format (combinational on dbi), word f:
  - byte_op=0: f=dbi.
  - byte_op=1: lane = odd ? dbi[15:8] : dbi[7:0].
  - Upper DW-8 bits are filled with lane[7] if sext=1, else 0.
  - For DW>16, the byte lanes are still [15:8] and [7:0].
- Priority per enabled edge is flush > (push, pop).
- flush=1:
  - rptr=wptr=0, count=0, overflow=0.
  - Any push or pop in the same cycle is discarded.
- Pop is effective when pop=1 and count>0:
  - rptr advances modulo DEPTH.
  - A pop while empty is ignored; no error.
- Push when count<DEPTH, or when full and an effective pop occurs in the same cycle:
  - f is written at wptr and wptr advances modulo DEPTH.
- Push when full with no effective pop:
  - OVERWRITE=0: the word is dropped and overflow is set to 1.
  - OVERWRITE=1: the entry at (wptr-1) mod DEPTH is replaced with f; pointers and count are unchanged; overflow is not set.
- count changes by +1 for a push only, -1 for a pop only, and 0 for both or neither. It never exceeds DEPTH.
- Push and pop in the same cycle when empty: the pop is ineffective and the push succeeds, so count becomes 1.
- Latency:
  - A word pushed at edge N appears on dout immediately after edge N if the queue was empty.
  - Otherwise it appears after the preceding entries are popped.
- dout is combinational from storage[rptr], gated by empty. It must be glitch-free relative to clkdbi, i.e. it is sampled only at edges.
- Pointer wrap is modulo DEPTH. For DEPTH=1, pointers are constant 0.
- overflow clears only on flush or reset; it does not clear on pop.
- A reset asserted mid-operation clears everything immediately, independent of the clock. Deassertion is synchronised externally.

Test Plan:
- Reset, then push 0x1234, 0xABCD, 0x0001 on consecutive edges -> count=3, dout=0x1234. Three pops -> dout sequence 0x1234, 0xABCD, 0x0001, then dout=0 and empty=1.
- byte_op=1 with dbi=0x80FF:
  - odd=0, sext=1 -> entry 0xFFFF.
  - odd=1, sext=1 -> 0xFF80.
  - odd=1, sext=0 -> 0x0080.
  - byte_op=0 -> 0x80FF.
- OVERWRITE=0, DEPTH=4: five pushes 1..5 -> full=1, overflow=1, popped order 1,2,3,4. A subsequent flush -> overflow=0, count=0.
- Full queue with simultaneous push(9) and pop -> count stays 4, head advances, 9 is popped last. Empty queue with push(7) and pop -> count=1, dout=7.
- DEPTH=1, OVERWRITE=1: push 0x1111 then 0x2222 -> dout=0x2222, overflow=0. Under cedbi=0, push/pop/flush cause no change.
- Assert reset_n=0 between clock edges with count=3 -> count=0, empty=1, dout=0 before the next edge.

Source files
------------

// File: rtl/dbi_capture_queue.sv
// Show-ahead capture queue for bus read data in the clkdbi domain.
// Byte-lane extraction and sign/zero extension are applied as each word is captured.
module dbi_capture_queue #(
  parameter int DW        = 16,
  parameter int DEPTH     = 4,
  parameter int CW        = 3,
  parameter int OVERWRITE = 0
) (
  input  logic          clkdbi,
  input  logic          reset_n,
  input  logic          cedbi,
  input  logic [DW-1:0] dbi,
  input  logic          push,
  input  logic          byte_op,
  input  logic          odd,
  input  logic          sext,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow
);

  // Pointers keep at least one bit; for DEPTH=1 they are held at zero.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MD = 1 << PW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem_r [MD];
  logic [PW-1:0] rptr_r;
  logic [PW-1:0] wptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic [7:0]    hi_lane_s;
  logic [7:0]    lane_s;
  logic [DW-1:0] fmt_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_eff_s;
  logic          push_ok_s;
  logic          push_ovw_s;
  logic          push_drop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (DEPTH == 1) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    if (DEPTH == 1) begin
      return {PW{1'b0}};
    end else begin
      return p - PW'(1'b1);
    end
  endfunction

  // A narrow 8-bit bus has no high lane; odd then selects the only byte.
  generate
    if (DW >= 16) begin : g_hi_lane
      assign hi_lane_s = dbi[15:8];
    end else begin : g_lo_only
      assign hi_lane_s = dbi[7:0];
    end
  endgenerate

  // Capture format: whole word, or one byte lane extended to DW bits.
  always_comb begin
    lane_s = odd ? hi_lane_s : dbi[7:0];
    if (byte_op) begin
      fmt_s      = {DW{sext & lane_s[7]}};
      fmt_s[7:0] = lane_s;
    end else begin
      fmt_s = dbi;
    end
  end

  // Push/pop qualification; a simultaneous pop frees the slot for a push into a full queue.
  always_comb begin
    empty_s     = (count_r == {CW{1'b0}});
    full_s      = (count_r == DEPTH_C);
    pop_eff_s   = pop & ~empty_s;
    push_ok_s   = push & (~full_s | pop_eff_s);
    push_ovw_s  = push & full_s & ~pop_eff_s & (OVERWRITE != 0);
    push_drop_s = push & full_s & ~pop_eff_s & (OVERWRITE == 0);
  end

  // Pointer, occupancy and sticky overflow state; flush wins over push and pop.
  always_ff @(posedge clkdbi or negedge reset_n) begin
    if (!reset_n) begin
      rptr_r     <= {PW{1'b0}};
      wptr_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else if (cedbi) begin
      if (flush) begin
        rptr_r     <= {PW{1'b0}};
        wptr_r     <= {PW{1'b0}};
        count_r    <= {CW{1'b0}};
        overflow_r <= 1'b0;
      end else begin
        if (pop_eff_s) rptr_r <= ptr_inc(rptr_r);
        if (push_ok_s) wptr_r <= ptr_inc(wptr_r);
        if (push_ok_s & ~pop_eff_s) begin
          count_r <= count_r + CW'(1'b1);
        end else if (pop_eff_s & ~push_ok_s) begin
          count_r <= count_r - CW'(1'b1);
        end
        if (push_drop_s) overflow_r <= 1'b1;
      end
    end
  end

  // Storage needs no reset: dout is gated by empty.
  always_ff @(posedge clkdbi) begin
    if (cedbi & ~flush) begin
      if (push_ok_s) begin
        mem_r[wptr_r] <= fmt_s;
      end else if (push_ovw_s) begin
        mem_r[ptr_dec(wptr_r)] <= fmt_s;
      end
    end
  end

  assign dout     = empty_s ? {DW{1'b0}} : mem_r[rptr_r];
  assign empty    = empty_s;
  assign full     = full_s;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_dbi_capture_queue.sv
// Self-checking bench: default DEPTH=4 queue plus a DEPTH=1 overwrite latch instance.
module tb_dbi_capture_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cedbi = 1'b1, push = 1'b0, pop = 1'b0, flush = 1'b0;
  logic        byte_op = 1'b0, odd = 1'b0, sext = 1'b0;
  logic [15:0] dbi = 16'h0000;
  logic [15:0] dout;
  logic        empty, full, overflow;
  logic [2:0]  count;

  logic        cedbi1 = 1'b1, push1 = 1'b0, pop1 = 1'b0, flush1 = 1'b0;
  logic [15:0] dbi1 = 16'h0000;
  logic [15:0] dout1;
  logic        empty1, full1, overflow1;
  logic [0:0]  count1;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic        bo;
    logic        od;
    logic        sx;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  dbi_capture_queue dut (
    .clkdbi(clk), .reset_n(reset_n), .cedbi(cedbi), .dbi(dbi), .push(push),
    .byte_op(byte_op), .odd(odd), .sext(sext), .pop(pop), .flush(flush),
    .dout(dout), .empty(empty), .full(full), .count(count), .overflow(overflow)
  );

  dbi_capture_queue #(.DW(16), .DEPTH(1), .CW(1), .OVERWRITE(1)) dut1 (
    .clkdbi(clk), .reset_n(reset_n), .cedbi(cedbi1), .dbi(dbi1), .push(push1),
    .byte_op(1'b0), .odd(1'b0), .sext(1'b0), .pop(pop1), .flush(flush1),
    .dout(dout1), .empty(empty1), .full(full1), .count(count1), .overflow(overflow1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [15:0] d, input logic bo, input logic od, input logic sx,
                         input logic [15:0] exp);
    dbi = d; byte_op = bo; odd = od; sext = sx; push = 1'b1;
    cyc();
    push = 1'b0; byte_op = 1'b0;
    sb.push_back(exp);
  endtask

  task automatic drain(input string name);
    logic [15:0] e;
    chk({name, "_count"}, 32'(count), 32'(sb.size()));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({name, "_dout"}, 32'(dout), 32'(e));
      pop = 1'b1;
      cyc();
      pop = 1'b0;
    end
    chk({name, "_empty"}, 32'(empty), 32'd1);
    chk({name, "_dout0"}, 32'(dout), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h1234, 16'h1234};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'hABCD, 16'hABCD};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h80FF, 16'hFFFF};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h80FF, 16'hFF80};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h80FF, 16'h0080};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h80FF, 16'h80FF};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h80FF, 16'h00FF};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 16'h7F00, 16'h007F};

    // reset state
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst1_empty", 32'(empty1), 32'd1);
    reset_n = 1'b1;
    cyc();

    // capture-format table, applied in groups of three
    for (int i = 0; i < 9; i++) begin
      do_push(vecs[i].d, vecs[i].bo, vecs[i].od, vecs[i].sx, vecs[i].exp);
      if (i == 2) chk("first_head", 32'(dout), 32'h1234);
      if ((i % 3) == 2) drain("fmt");
    end

    // pop while empty is ignored
    pop = 1'b1; cyc(); pop = 1'b0;
    chk("pop_empty_count", 32'(count), 32'd0);

    // overflow: fifth push dropped
    for (int i = 1; i <= 5; i++) begin
      do_push(16'(i), 1'b0, 1'b0, 1'b0, 16'(i));
    end
    void'(sb.pop_back());
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain("ovf");
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_push(16'h0042, 1'b0, 1'b0, 1'b0, 16'h0042);
    void'(sb.pop_back());
    flush = 1'b1; push = 1'b1; dbi = 16'h0099;
    cyc();
    flush = 1'b0; push = 1'b0;
    chk("flush_ovf", 32'(overflow), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);

    // full queue with simultaneous push and pop
    for (int i = 1; i <= 4; i++) do_push(16'(i), 1'b0, 1'b0, 1'b0, 16'(i));
    chk("pp_head_before", 32'(dout), 32'(sb[0]));
    dbi = 16'h0009; push = 1'b1; pop = 1'b1;
    cyc();
    push = 1'b0; pop = 1'b0;
    void'(sb.pop_front());
    sb.push_back(16'h0009);
    chk("pp_full_count", 32'(count), 32'd4);
    chk("pp_full_ovf", 32'(overflow), 32'd0);
    drain("pp_full");

    // empty queue with simultaneous push and pop
    dbi = 16'h0007; push = 1'b1; pop = 1'b1;
    cyc();
    push = 1'b0; pop = 1'b0;
    sb.push_back(16'h0007);
    chk("pp_empty_count", 32'(count), 32'd1);
    drain("pp_empty");

    // clock enable low freezes the main queue
    do_push(16'h0055, 1'b0, 1'b0, 1'b0, 16'h0055);
    cedbi = 1'b0; push = 1'b1; pop = 1'b1; flush = 1'b1; dbi = 16'h0066;
    cyc();
    cedbi = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
    drain("ce_hold");

    // DEPTH=1 overwrite latch
    dbi1 = 16'h1111; push1 = 1'b1; cyc();
    chk("d1_first", 32'(dout1), 32'h1111);
    chk("d1_full", 32'(full1), 32'd1);
    dbi1 = 16'h2222; cyc();
    push1 = 1'b0;
    chk("d1_ovw", 32'(dout1), 32'h2222);
    chk("d1_ovf", 32'(overflow1), 32'd0);
    chk("d1_count", 32'(count1), 32'd1);
    cedbi1 = 1'b0; push1 = 1'b1; pop1 = 1'b1; flush1 = 1'b1; dbi1 = 16'h3333;
    cyc();
    cedbi1 = 1'b1; push1 = 1'b0; pop1 = 1'b0; flush1 = 1'b0;
    chk("d1_ce_dout", 32'(dout1), 32'h2222);
    chk("d1_ce_count", 32'(count1), 32'd1);
    pop1 = 1'b1; cyc(); pop1 = 1'b0;
    chk("d1_pop_empty", 32'(empty1), 32'd1);

    // asynchronous reset between edges
    for (int i = 0; i < 3; i++) do_push(16'(16'hA0 + i), 1'b0, 1'b0, 1'b0, 16'(16'hA0 + i));
    chk("mid_count3", 32'(count), 32'd3);
    sb.delete();
    #1 reset_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_dout", 32'(dout), 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
